// File: rtl/matrix_scalar_mul_seq_pkg.sv
// Shared definitions for the sequential matrix-by-scalar multiplier.
//   - MAX_DIM / ELEM_W / SCALAR_W defaults
//   - state_t : IDLE, RUN, DONE
//   - elem_lsb(r,c) : LSB of element (r,c) in the packed row-major matrix
//   - dim_legal(d)  : 1 <= d <= MAX_DIM
package matrix_pkg;

  localparam int MAX_DIM  = 5;
  localparam int ELEM_W   = 8;
  localparam int SCALAR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int elem_lsb(input int r, input int c,
                                  input int max_dim = MAX_DIM,
                                  input int elem_w  = ELEM_W);
    return (r * max_dim + c) * elem_w;
  endfunction

  function automatic logic dim_legal(input int d, input int max_dim = MAX_DIM);
    return (d >= 1) && (d <= max_dim);
  endfunction

endpackage

// File: rtl/matrix_scalar_mul_seq_if.sv
// Request/response bundle for matrix_scalar_mul_seq.
//   master : drives start, m, n, scalar, mat_in; observes results/status
//   slave  : the multiplier side
interface matrix_scalar_mul_seq_if #(
  parameter int MAX_DIM  = 5,
  parameter int ELEM_W   = 8,
  parameter int SCALAR_W = 4
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam int MAT_W = MAX_DIM * MAX_DIM * ELEM_W;

  logic                start;
  logic [DIM_W-1:0]    m;
  logic [DIM_W-1:0]    n;
  logic [SCALAR_W-1:0] scalar;
  logic [MAT_W-1:0]    mat_in;
  logic [MAT_W-1:0]    mat_out;
  logic                busy;
  logic                done;
  logic                valid;
  logic                error;
  logic                overflow;

  modport master (
    output start, m, n, scalar, mat_in,
    input  mat_out, busy, done, valid, error, overflow
  );

  modport slave (
    input  start, m, n, scalar, mat_in,
    output mat_out, busy, done, valid, error, overflow
  );
endinterface

// File: rtl/matrix_scalar_mul_seq_lane.sv
// scalar_mul_lane: one unsigned ELEM_W x SCALAR_W multiplier.
//   i_elem, i_scalar : operands
//   o_result         : ELEM_W-bit result (clamped or truncated)
//   o_ovf            : full product does not fit in ELEM_W bits
// Optional feature: MATRIX_SCALAR_SAT_EN clamps overflowing products to all
// ones; otherwise the low ELEM_W bits are kept.
module scalar_mul_lane #(
  parameter int ELEM_W   = 8,
  parameter int SCALAR_W = 4
) (
  input  logic [ELEM_W-1:0]   i_elem,
  input  logic [SCALAR_W-1:0] i_scalar,
  output logic [ELEM_W-1:0]   o_result,
  output logic                o_ovf
);
  logic [ELEM_W+SCALAR_W-1:0] w_prod;

  assign w_prod = (ELEM_W+SCALAR_W)'(i_elem) * (ELEM_W+SCALAR_W)'(i_scalar);
  assign o_ovf  = |w_prod[ELEM_W+SCALAR_W-1:ELEM_W];

`ifdef MATRIX_SCALAR_SAT_EN
  assign o_result = o_ovf ? {ELEM_W{1'b1}} : w_prod[ELEM_W-1:0];
`else
  assign o_result = w_prod[ELEM_W-1:0];
`endif
endmodule

// File: rtl/matrix_scalar_mul_seq.sv
// matrix_scalar_mul_seq: sequential matrix-by-scalar multiplier.
// One element per clock in row-major order through a single lane.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of matrix_scalar_mul_seq_if
//                start/m/n/scalar/mat_in in; mat_out/busy/done/valid/error/overflow out
// Optional feature macro: MATRIX_SCALAR_SAT_EN (saturate instead of truncate,
// implemented inside scalar_mul_lane).
module matrix_scalar_mul_seq
  import matrix_pkg::*;
#(
  parameter int MAX_DIM  = matrix_pkg::MAX_DIM,
  parameter int ELEM_W   = matrix_pkg::ELEM_W,
  parameter int SCALAR_W = matrix_pkg::SCALAR_W
) (
  input  logic clk,
  input  logic reset,
  matrix_scalar_mul_seq_if.slave bus
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam int MAT_W = MAX_DIM * MAX_DIM * ELEM_W;

  state_t              r_state, w_next;
  logic [DIM_W-1:0]    r_m, r_n, r_row, r_col;
  logic [SCALAR_W-1:0] r_scalar;
  logic [MAT_W-1:0]    r_mat_in, r_mat_out;
  logic                r_valid, r_error, r_ovf;

  logic                w_start, w_legal, w_last_col, w_last;
  int                  w_lsb;
  logic [ELEM_W-1:0]   w_elem, w_res;
  logic                w_ovf;

  // start only matters in IDLE; anything else is dropped, not queued
  assign w_start    = (r_state == IDLE) && bus.start;
  assign w_legal    = dim_legal(int'(bus.m), MAX_DIM) && dim_legal(int'(bus.n), MAX_DIM);
  assign w_last_col = (r_col == r_n - DIM_W'(1));
  assign w_last     = w_last_col && (r_row == r_m - DIM_W'(1));

  // row/col stay inside the latched m x n window, so the select is in range
  assign w_lsb  = elem_lsb(int'(r_row), int'(r_col), MAX_DIM, ELEM_W);
  assign w_elem = r_mat_in[w_lsb +: ELEM_W];

  scalar_mul_lane #(.ELEM_W(ELEM_W), .SCALAR_W(SCALAR_W)) u_lane (
    .i_elem   (w_elem),
    .i_scalar (r_scalar),
    .o_result (w_res),
    .o_ovf    (w_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = w_legal ? RUN : DONE;
      RUN:     if (w_last)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m       <= '0;
      r_n       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_scalar  <= '0;
      r_mat_in  <= '0;
      r_mat_out <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_mat_out <= '0;
          r_ovf     <= 1'b0;
          r_valid   <= 1'b0;
          r_row     <= '0;
          r_col     <= '0;
          r_error   <= !w_legal;
          if (w_legal) begin
            r_m      <= bus.m;
            r_n      <= bus.n;
            r_scalar <= bus.scalar;
            r_mat_in <= bus.mat_in;
          end
        end
        RUN: begin
          r_mat_out[w_lsb +: ELEM_W] <= w_res;
          r_ovf <= r_ovf | w_ovf;
          if (w_last) begin
            r_valid <= 1'b1;
          end else if (w_last_col) begin
            r_col <= '0;
            r_row <= r_row + DIM_W'(1);
          end else begin
            r_col <= r_col + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mat_out  = r_mat_out;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.valid    = r_valid;
  assign bus.error    = r_error;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_matrix_scalar_mul_seq.sv
// Directed bench for matrix_scalar_mul_seq. Cycle 0 is the cycle whose
// closing edge accepts start; outputs are sampled 1ns after rising edges.
module tb_matrix_scalar_mul_seq;
  localparam int MD    = 5;
  localparam int EW    = 8;
  localparam int SW    = 4;
  localparam int DIM_W = $clog2(MD + 1);
  localparam int MW    = MD * MD * EW;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  matrix_scalar_mul_seq_if #(.MAX_DIM(MD), .ELEM_W(EW), .SCALAR_W(SW)) bus ();

  matrix_scalar_mul_seq #(.MAX_DIM(MD), .ELEM_W(EW), .SCALAR_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] put(input logic [MW-1:0] v, input int r, input int c, input int e);
    logic [MW-1:0] t;
    t = v;
    t[(r*MD + c)*EW +: EW] = EW'(e);
    return t;
  endfunction

  // Launch one operation and wait for done; dcyc = cycle of done, -1 on timeout.
  // mat_in is scrambled right after acceptance to prove it was latched.
  task automatic run_op(input int mm, input int nn, input int sc,
                        input logic [MW-1:0] mat, output int dcyc);
    @(negedge clk);
    while (bus.busy) @(negedge clk);
    bus.m = DIM_W'(mm); bus.n = DIM_W'(nn); bus.scalar = SW'(sc);
    bus.mat_in = mat; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mat_in = ~mat;
    dcyc = 1;
    while (!bus.done && dcyc < 100) begin
      @(posedge clk); #1; dcyc++;
    end
    if (!bus.done) dcyc = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.m = '0; bus.n = '0; bus.scalar = '0; bus.mat_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.valid, bus.error, bus.overflow} !== 5'b0) begin
      errors++; $display("FAIL reset_status: got %b expected 00000",
        {bus.busy, bus.done, bus.valid, bus.error, bus.overflow});
    end
    checks++;
    if (bus.mat_out !== '0) begin
      errors++; $display("FAIL reset_mat_out: got %h expected 0", bus.mat_out);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic_2x3;
    logic [MW-1:0] mi, ex;
    int d;
    mi = '0; ex = '0;
    mi = put(mi,0,0,1); mi = put(mi,0,1,2); mi = put(mi,0,2,3);
    mi = put(mi,1,0,3); mi = put(mi,1,1,4); mi = put(mi,1,2,5);
    ex = put(ex,0,0,3); ex = put(ex,0,1,6); ex = put(ex,0,2,9);
    ex = put(ex,1,0,9); ex = put(ex,1,1,12); ex = put(ex,1,2,15);
    run_op(2, 3, 3, mi, d);
    checks++; if (d !== 7) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 7", d); end
    checks++; if (bus.mat_out !== ex) begin errors++; $display("FAIL basic_mat_out: got %h expected %h", bus.mat_out, ex); end
    checks++; if ({bus.valid, bus.error, bus.overflow, bus.busy} !== 4'b1001) begin
      errors++; $display("FAIL basic_flags: got %b expected 1001", {bus.valid, bus.error, bus.overflow, bus.busy});
    end
    @(posedge clk); #1;
    checks++; if ({bus.done, bus.busy, bus.valid} !== 3'b001) begin
      errors++; $display("FAIL basic_after_done: got %b expected 001", {bus.done, bus.busy, bus.valid});
    end
  endtask

  task automatic test_illegal;
    int d;
    run_op(0, 3, 2, {MW{1'b1}}, d);
    checks++; if (d !== 1) begin errors++; $display("FAIL illegal_m0_cycle: got %0d expected 1", d); end
    checks++; if ({bus.error, bus.valid} !== 2'b10) begin errors++; $display("FAIL illegal_m0_flags: got %b expected 10", {bus.error, bus.valid}); end
    checks++; if (bus.mat_out !== '0) begin errors++; $display("FAIL illegal_m0_mat: got %h expected 0", bus.mat_out); end
    run_op(6, 2, 2, {MW{1'b1}}, d);
    checks++; if (d !== 1) begin errors++; $display("FAIL illegal_m6_cycle: got %0d expected 1", d); end
    checks++; if ({bus.error, bus.valid, bus.busy} !== 3'b101) begin errors++; $display("FAIL illegal_m6_flags: got %b expected 101", {bus.error, bus.valid, bus.busy}); end
    checks++; if (bus.mat_out !== '0) begin errors++; $display("FAIL illegal_m6_mat: got %h expected 0", bus.mat_out); end
  endtask

  task automatic test_overflow;
    logic [MW-1:0] mi, ex;
    int d;
    mi = put('0, 0, 0, 100);
`ifdef MATRIX_SCALAR_SAT_EN
    ex = put('0, 0, 0, 255);
`else
    ex = put('0, 0, 0, 44);
`endif
    run_op(1, 1, 3, mi, d);
    checks++; if (d !== 2) begin errors++; $display("FAIL ovf_done_cycle: got %0d expected 2", d); end
    checks++; if (bus.mat_out !== ex) begin errors++; $display("FAIL ovf_mat_out: got %h expected %h", bus.mat_out, ex); end
    checks++; if ({bus.overflow, bus.valid, bus.error} !== 3'b110) begin
      errors++; $display("FAIL ovf_flags: got %b expected 110", {bus.overflow, bus.valid, bus.error});
    end
  endtask

  task automatic test_full_5x5;
    logic [MW-1:0] mi;
    int d;
    mi = '0;
    for (int i = 0; i < MD*MD; i++) mi[i*EW +: EW] = 8'd17;
    run_op(5, 5, 15, mi, d);
    checks++; if (d !== 26) begin errors++; $display("FAIL full_done_cycle: got %0d expected 26", d); end
    checks++; if (bus.mat_out !== {MW{1'b1}}) begin errors++; $display("FAIL full_mat_out: got %h expected all ff", bus.mat_out); end
    checks++; if ({bus.overflow, bus.valid} !== 2'b01) begin errors++; $display("FAIL full_flags: got %b expected 01", {bus.overflow, bus.valid}); end
  endtask

  task automatic test_scalar_zero;
    logic [MW-1:0] mi;
    int d;
    mi = put('0, 0, 0, 200); mi = put(mi, 1, 1, 9);
    run_op(2, 2, 0, mi, d);
    checks++; if (d !== 5) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 5", d); end
    checks++; if ({bus.mat_out == '0, bus.valid, bus.overflow} !== 3'b110) begin
      errors++; $display("FAIL zero_result: got mat %h valid %b ovf %b expected 0 1 0", bus.mat_out, bus.valid, bus.overflow);
    end
  endtask

  task automatic test_start_while_busy;
    logic [MW-1:0] mi, ex, cap;
    int ndone, dcyc;
    mi = '0; ex = '0; cap = '0; ndone = 0; dcyc = -1;
    mi = put(mi,0,0,1); mi = put(mi,0,1,2); mi = put(mi,1,0,3); mi = put(mi,1,1,4);
    ex = put(ex,0,0,2); ex = put(ex,0,1,4); ex = put(ex,1,0,6); ex = put(ex,1,1,8);
    @(negedge clk);
    while (bus.busy) @(negedge clk);
    bus.m = 3'd2; bus.n = 3'd2; bus.scalar = 4'd2; bus.mat_in = mi; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_cycle1: got %b expected 1", bus.busy); end
      end
      if (bus.done) begin ndone++; dcyc = c; cap = bus.mat_out; end
      bus.start  = (c == 2 || c == 4);
      bus.scalar = 4'd7;
      bus.m      = 3'd1; bus.n = 3'd1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", ndone); end
    checks++; if (dcyc !== 5) begin errors++; $display("FAIL busy_done_cycle: got %0d expected 5", dcyc); end
    checks++; if (cap !== ex) begin errors++; $display("FAIL busy_result: got %h expected %h", cap, ex); end
  endtask

  task automatic test_reset_abort;
    logic [MW-1:0] mi, ex;
    int d, seen;
    mi = '0; ex = '0; seen = 0;
    for (int i = 0; i < 9; i++) begin
      mi = put(mi, i/3, i%3, i+1);
      ex = put(ex, i/3, i%3, 2*(i+1));
    end
    @(negedge clk);
    while (bus.busy) @(negedge clk);
    bus.m = 3'd3; bus.n = 3'd3; bus.scalar = 4'd1; bus.mat_in = mi; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk);   // now in cycle 3
    #2 reset = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.done, bus.valid, bus.error, bus.overflow} !== 5'b0) begin
      errors++; $display("FAIL abort_status: got %b expected 00000", {bus.busy, bus.done, bus.valid, bus.error, bus.overflow});
    end
    checks++; if (bus.mat_out !== '0) begin errors++; $display("FAIL abort_mat_out: got %h expected 0", bus.mat_out); end
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    @(negedge clk); reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
    run_op(3, 3, 2, mi, d);
    checks++; if (d !== 10) begin errors++; $display("FAIL abort_restart_cycle: got %0d expected 10", d); end
    checks++; if (bus.mat_out !== ex) begin errors++; $display("FAIL abort_restart_mat: got %h expected %h", bus.mat_out, ex); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL abort_restart_valid: got %b expected 1", bus.valid); end
  endtask

  initial begin
    test_reset();
    test_basic_2x3();
    test_illegal();
    test_overflow();
    test_full_5x5();
    test_scalar_zero();
    test_start_while_busy();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/matrix_scalar_mul_seq.md
# matrix_scalar_mul_seq

Sequential, parametrised matrix-by-scalar multiplier for the matrix calculator datapath. It accepts one packed matrix of up to MAX_DIM×MAX_DIM unsigned elements plus a scalar on a start pulse, and computes one element per clock in row-major order. It reports completion with a one-cycle done pulse, or an error for illegal dimensions. It succeeds the fixed 5×5/8-bit combinational scalar unit, adding parametric sizing, a start/busy/done handshake and optional saturation.

## Interface
- MAX_DIM, 5, maximum rows/columns
- ELEM_W, 8, element width (unsigned)
- SCALAR_W, 4, scalar width (unsigned)
- DIM_W, $clog2(MAX_DIM+1), width of m/n (derived, not overridden)
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  request; sampled only in IDLE
- m  input  DIM_W  row count, legal 1..MAX_DIM
- n  input  DIM_W  column count, legal 1..MAX_DIM
- scalar  input  SCALAR_W  multiplier
- mat_in  input  MAX_DIM*MAX_DIM*ELEM_W  element (r,c) at bits [(r*MAX_DIM+c)*ELEM_W +: ELEM_W]
- mat_out  output  MAX_DIM*MAX_DIM*ELEM_W  result, same packing
- busy  output  1  high from acceptance through the done cycle
- done  output  1  one-cycle completion pulse
- valid  output  1  last operation had legal dimensions; held until next accepted start
- error  output  1  last operation had illegal dimensions; held until next accepted start
- overflow  output  1  sticky: some product exceeded 2^ELEM_W-1 during last operation

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1 and legal m,n:
  - latch m, n, scalar and mat_in
  - clear mat_out, valid, error and overflow
  - set row=col=0; go to RUN.
- IDLE with start=1 and illegal m or n (0 or >MAX_DIM):
  - clear mat_out; set error=1, valid=0
  - go to DONE.
- RUN, once per cycle:
  - compute product = latched_elem(row,col) × scalar, full width ELEM_W+SCALAR_W
  - write the result to mat_out(row,col)
  - advance col; at col=n-1 wrap col to 0 and increment row
  - after element (m-1,n-1) set valid=1 and go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- Elements outside m×n stay zero in mat_out.
- start while busy is ignored and not queued.
- mat_in changes after acceptance do not affect the result.
- Scalar 0 yields an all-zero m×n result with valid=1.
- overflow is set when any product's upper SCALAR_W bits are nonzero; it stays set until the next accepted start.

## Timing
- Reset value of every output, and of the state register, is 0.
- Acceptance occurs at cycle 0, on the start edge.
- Element k in row-major order is written at the end of cycle k+1.
- RUN lasts m*n cycles; done is high in cycle m*n+1; start is accepted again from cycle m*n+2.
- For illegal dimensions, done and error are both visible in cycle 1.
- busy=1 from cycle 1 through the done cycle inclusive.
- valid and mat_out are stable when done is high.
- Reset asserted mid-RUN aborts asynchronously: state goes to IDLE and all outputs clear. There is no done pulse for the aborted operation.

## Configuration
- MATRIX_SCALAR_SAT_EN defined: a product above 2^ELEM_W-1 is clamped to all ones, and overflow behaves as above.
- Without the macro: the result is product modulo 2^ELEM_W (truncation), and overflow is still reported.

## Structure
- Shared package matrix_pkg:
  - MAX_DIM and ELEM_W defaults
  - state enum {IDLE, RUN, DONE}
  - function elem_lsb(r,c) returning (r*MAX_DIM+c)*ELEM_W
  - dimension-legality function
- Sub-module scalar_mul_lane:
  - one ELEM_W×SCALAR_W unsigned multiplier
  - saturation/truncation selected by MATRIX_SCALAR_SAT_EN
  - outputs result[ELEM_W-1:0] and ovf.

## Test plan
- 2×3 matrix [[1,2,3],[3,4,5]], scalar 3, start at cycle 0 → done in cycle 7; mat_out rows [3,6,9],[9,12,15]; valid=1, error=0; other 19 elements 0.
- m=0, n=3, then m=6, n=2 → each produces done in cycle 1 with error=1, valid=0, mat_out all zero.
- 1×1 element 100, scalar 3:
  - with macro → 255, overflow=1
  - without macro → 44, overflow=1.
- 5×5 all elements 17, scalar 15 → 25 RUN cycles; done in cycle 26; all 255; overflow=0.
- start pulsed in cycles 2 and 4 during a 2×2 operation → ignored; single done in cycle 5; result unchanged.
- reset asserted in cycle 3 of a 3×3 operation → all outputs 0 immediately; no done pulse; new start after release completes normally.
